regfile_rename: RTL
===================

Name: regfile_rename

Overview:
- Architectural register file with per-register rename status, for the out-of-order core.
- Sits directly downstream of the reorder buffer's commit point and beside issue:
  - issue marks rd as pending on a RoB tag;
  - RoB commit writes the value back and clears the pending mark if the tag still matches;
  - two read ports give issue each source operand as a value or a RoB tag to wait on.
- Branch-mispredict flush clears all pending marks.

Parameters:
- BITS, 4, RoB tag width (RoB depth = 2**BITS)
- NUM_REGS, 32, number of architectural registers; register x0 is hardwired to zero

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous active-low reset
- rdy_in  input  1  when low, freezes all state (reads stay combinational)
- flush_in  input  1  mispredict flush; clears every busy bit
- issue_valid  input  1  instruction issued this cycle with a destination register
- issue_rd  input  5  destination register of the issued instruction
- issue_tag  input  BITS  RoB entry allocated to the issued instruction
- commit_valid  input  1  RoB head commits a register write this cycle
- commit_rd  input  5  destination register of the committing instruction
- commit_tag  input  BITS  RoB entry of the committing instruction
- commit_value  input  32  result being committed
- rs1  input  5  source register 1 address
- rs2  input  5  source register 2 address
- rs1_busy  output  1  rs1 is waiting on an in-flight producer
- rs1_tag  output  BITS  RoB tag of rs1's producer (valid when rs1_busy)
- rs1_value  output  32  rs1 value (valid when !rs1_busy)
- rs2_busy, rs2_tag, rs2_value  output  1/BITS/32  same as rs1_* for rs2

Behaviour:
- State per register: value[31:0], busy, tag[BITS-1:0].
- Reset (rst_n_in low, asynchronous): all value=0, busy=0, tag=0.
  - Outputs therefore read busy=0, tag=0, value=0.
  - Reset mid-operation discards all pending marks immediately.
- All updates occur on posedge clk_in and only when rdy_in=1. With rdy_in=0, no state changes and inputs are ignored.
- Commit (commit_valid && commit_rd!=0):
  - value[commit_rd] <= commit_value, regardless of tag.
  - busy[commit_rd] <= 0 only if busy[commit_rd] && tag[commit_rd]==commit_tag; otherwise busy/tag are unchanged (a younger producer exists).
- Issue (issue_valid && issue_rd!=0 && !flush_in): busy[issue_rd] <= 1, tag[issue_rd] <= issue_tag.
- Issue and commit to the same rd in the same cycle:
  - value is written from the commit;
  - busy=1 and tag=issue_tag (issue wins).
- Flush (flush_in=1):
  - all busy <= 0;
  - a same-cycle commit still writes its value;
  - a same-cycle issue is dropped.
- x0: never busy, always reads value 0, tag 0; issue/commit to x0 ignored.
- Reads are combinational, zero latency, and reflect state before the current edge.
  - A same-cycle issue does not affect reads, so an instruction reading and writing the same register sees the old producer.
- Tag equality is exact BITS-bit compare. Tag wrap-around is safe because the RoB never holds two live entries with the same tag.

Optional Feature:
- REGFILE_COMMIT_BYPASS_EN defined: when commit_valid && commit_rd==rsN && rsN!=0 && busy[rsN] && tag[rsN]==commit_tag, the read port returns rsN_busy=0 and rsN_value=commit_value in the same cycle.
- Undefined: the read port returns the pre-commit state (busy=1, old tag). The RoB operand lookup covers that case one cycle later.

Decomposition:
- Shared package constants: REG_ADDR_W=5, NUM_REGS=32, ROB_TAG_W (=BITS), XLEN=32, ZERO_REG=0.
- One natural sub-module, regfile_read_port: mux plus optional bypass compare for one source operand, instantiated twice (rs1, rs2).

Test Plan:
- Reset low mid-run after issue to x5 -> immediately rs1=5 reads busy=0, tag=0, value=0.
- Issue rd=5 tag=3; next cycle rs1=5 -> busy=1, tag=3. Commit rd=5 tag=3 value=0xDEADBEEF; next cycle -> busy=0, value=0xDEADBEEF.
- Issue rd=7 tag=2, then issue rd=7 tag=6, then commit rd=7 tag=2 value=0x11 -> busy=1, tag=6, value=0x11. Commit tag=6 value=0x22 -> busy=0, value=0x22.
- Same cycle: issue rd=9 tag=4 and commit rd=9 (prior tag=1) value=0x55 -> busy=1, tag=4, value=0x55.
- Pending rd=3 tag=1 and rd=8 tag=2, then flush_in=1 with issue rd=10 tag=5 -> all busy=0, x10 not busy. Repeat with rdy_in=0 -> no state change.
- Issue/commit to x0 with value 0x1234 -> rs2=0 reads busy=0, value=0.
- With REGFILE_COMMIT_BYPASS_EN: rd=4 pending tag=7, commit tag=7 value=0xAB while rs1=4 -> same-cycle busy=0, value=0xAB. Without the macro -> busy=1, tag=7 that cycle.

Source files
------------

// File: rtl/regfile_rename_pkg.sv
// Shared constants for the rename-aware architectural register file.
package regfile_rename_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int ROB_TAG_W  = 4;
    localparam int XLEN       = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;
endpackage

// File: rtl/regfile_rename_if.sv
// Issue, commit and operand-read signals between the core and the register file.
interface regfile_rename_if
    import regfile_rename_pkg::*;
#(
    parameter int BITS = ROB_TAG_W
);
    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_rd;
    logic [BITS-1:0]       issue_tag;
    logic                  commit_valid;
    logic [REG_ADDR_W-1:0] commit_rd;
    logic [BITS-1:0]       commit_tag;
    logic [XLEN-1:0]       commit_value;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  rs1_busy;
    logic [BITS-1:0]       rs1_tag;
    logic [XLEN-1:0]       rs1_value;
    logic                  rs2_busy;
    logic [BITS-1:0]       rs2_tag;
    logic [XLEN-1:0]       rs2_value;

    modport master (
        output issue_valid, issue_rd, issue_tag,
        output commit_valid, commit_rd, commit_tag, commit_value,
        output rs1, rs2,
        input  rs1_busy, rs1_tag, rs1_value, rs2_busy, rs2_tag, rs2_value
    );

    modport slave (
        input  issue_valid, issue_rd, issue_tag,
        input  commit_valid, commit_rd, commit_tag, commit_value,
        input  rs1, rs2,
        output rs1_busy, rs1_tag, rs1_value, rs2_busy, rs2_tag, rs2_value
    );
endinterface

// File: rtl/regfile_rename_read_port.sv
// One source-operand read port: register select plus, with REGFILE_COMMIT_BYPASS_EN,
// forwarding of a same-cycle matching commit.
module regfile_read_port
    import regfile_rename_pkg::*;
#(
    parameter int BITS     = ROB_TAG_W,
    parameter int NUM_REGS = 32
) (
    input  logic [REG_ADDR_W-1:0]          rs,
    input  logic [NUM_REGS-1:0]            busy_vec,
    input  logic [NUM_REGS-1:0][BITS-1:0]  tag_vec,
    input  logic [NUM_REGS-1:0][XLEN-1:0]  value_vec,
`ifdef REGFILE_COMMIT_BYPASS_EN
    input  logic                           commit_valid,
    input  logic [REG_ADDR_W-1:0]          commit_rd,
    input  logic [BITS-1:0]                commit_tag,
    input  logic [XLEN-1:0]                commit_value,
`endif
    output logic                           busy,
    output logic [BITS-1:0]                tag,
    output logic [XLEN-1:0]                value
);
    always_comb begin
        busy  = busy_vec[rs];
        tag   = tag_vec[rs];
        value = value_vec[rs];
`ifdef REGFILE_COMMIT_BYPASS_EN
        // Only the producer the operand is actually waiting on may be forwarded.
        if (commit_valid && commit_rd == rs && rs != ZERO_REG &&
            busy_vec[rs] && tag_vec[rs] == commit_tag) begin
            busy  = 1'b0;
            value = commit_value;
        end
`endif
    end
endmodule

// File: rtl/regfile_rename.sv
// Architectural register file with per-register busy/RoB-tag rename state.
// Optional same-cycle commit forwarding on reads: define REGFILE_COMMIT_BYPASS_EN.
module regfile_rename
    import regfile_rename_pkg::*;
#(
    parameter int BITS     = ROB_TAG_W,
    parameter int NUM_REGS = 32
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    regfile_rename_if.slave   bus
);
    logic [NUM_REGS-1:0]           busy_q;
    logic [NUM_REGS-1:0][BITS-1:0] tag_q;
    logic [NUM_REGS-1:0][XLEN-1:0] value_q;
    logic                          commit_en;
    logic                          commit_hit;
    logic                          issue_en;

    assign commit_en  = bus.commit_valid && bus.commit_rd != ZERO_REG;
    assign commit_hit = commit_en && busy_q[bus.commit_rd] &&
                        tag_q[bus.commit_rd] == bus.commit_tag;
    assign issue_en   = bus.issue_valid && bus.issue_rd != ZERO_REG && !flush_in;

    // Issue is applied last so a same-cycle issue overrides the commit's busy clear.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy_q  <= '0;
            tag_q   <= '0;
            value_q <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                busy_q <= '0;
            end
            if (commit_en) begin
                value_q[bus.commit_rd] <= bus.commit_value;
                if (commit_hit) begin
                    busy_q[bus.commit_rd] <= 1'b0;
                end
            end
            if (issue_en) begin
                busy_q[bus.issue_rd] <= 1'b1;
                tag_q[bus.issue_rd]  <= bus.issue_tag;
            end
        end
    end

    regfile_read_port #(.BITS(BITS), .NUM_REGS(NUM_REGS)) u_rs1 (
        .rs           (bus.rs1),
        .busy_vec     (busy_q),
        .tag_vec      (tag_q),
        .value_vec    (value_q),
`ifdef REGFILE_COMMIT_BYPASS_EN
        .commit_valid (bus.commit_valid),
        .commit_rd    (bus.commit_rd),
        .commit_tag   (bus.commit_tag),
        .commit_value (bus.commit_value),
`endif
        .busy         (bus.rs1_busy),
        .tag          (bus.rs1_tag),
        .value        (bus.rs1_value)
    );

    regfile_read_port #(.BITS(BITS), .NUM_REGS(NUM_REGS)) u_rs2 (
        .rs           (bus.rs2),
        .busy_vec     (busy_q),
        .tag_vec      (tag_q),
        .value_vec    (value_q),
`ifdef REGFILE_COMMIT_BYPASS_EN
        .commit_valid (bus.commit_valid),
        .commit_rd    (bus.commit_rd),
        .commit_tag   (bus.commit_tag),
        .commit_value (bus.commit_value),
`endif
        .busy         (bus.rs2_busy),
        .tag          (bus.rs2_tag),
        .value        (bus.rs2_value)
    );
endmodule
